// File: rtl/instr_mem_responder_pkg.sv
// Shared widths, reset pattern and types for the instruction-memory responder.
package instr_mem_responder_pkg;

    localparam int INT_DATA_W      = 32;
    localparam int INSTR_MEM_IDX_W = 4;
    localparam int INSTR_MEM_DEPTH = 2 ** INSTR_MEM_IDX_W;

    // addi x0, x0, 0
    localparam logic [INT_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IMEM_INIT  = 1'b0,
        IMEM_READY = 1'b1
    } imem_state_e;

    typedef struct packed {
        logic                       valid;
        logic [INSTR_MEM_IDX_W-1:0] addr;
        logic [INT_DATA_W-1:0]      data;
    } imem_resp_t;

    function automatic logic is_last_idx(input logic [INSTR_MEM_IDX_W-1:0] idx);
        return &idx;
    endfunction

endpackage

// File: rtl/instr_mem_responder_resp_pipe.sv
// Fixed-depth response shift register; stall freezes it, flush kills every valid.
module imem_resp_pipe
    import instr_mem_responder_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INSTR_MEM_IDX_W-1:0] in_addr,
    input  logic [INT_DATA_W-1:0]      in_data,
    output logic                       out_valid,
    output logic [INSTR_MEM_IDX_W-1:0] out_addr,
    output logic [INT_DATA_W-1:0]      out_data
);

    imem_resp_t stage_r [LATENCY];
    imem_resp_t in_s;

    // Pack the incoming read result into one stage word
    always_comb begin
        in_s       = '0;
        in_s.valid = in_valid;
        in_s.addr  = in_addr;
        in_s.data  = in_data;
    end

    // Advance, hold or kill the stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_r[i].valid <= 1'b0;
            end
        end else if (!stall) begin
            stage_r[0] <= in_s;
            for (int i = 1; i < LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end else begin
            stage_r <= stage_r;
        end
    end

    assign out_valid = stage_r[LATENCY-1].valid;
    assign out_addr  = stage_r[LATENCY-1].addr;
    assign out_data  = stage_r[LATENCY-1].data;

endmodule

// File: rtl/instr_mem_responder.sv
// Word-addressed instruction memory with a NOP-fill sequence after reset and a
// fixed-latency response pipeline for the fetch stage.
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int                    LATENCY   = 1,
    parameter logic [INT_DATA_W-1:0] INIT_WORD = NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       imem_req_valid,
    input  logic [INSTR_MEM_IDX_W-1:0] imem_req_addr,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       load_en,
    input  logic [INSTR_MEM_IDX_W-1:0] load_addr,
    input  logic [INT_DATA_W-1:0]      load_data,
    output logic                       imem_resp_valid,
    output logic [INT_DATA_W-1:0]      imem_resp_data,
    output logic [INSTR_MEM_IDX_W-1:0] imem_resp_addr,
    output logic                       busy
);

    logic [INT_DATA_W-1:0]      mem_r [INSTR_MEM_DEPTH];
    imem_state_e                state_r;
    logic [INSTR_MEM_IDX_W-1:0] cnt_r;
    logic                       busy_r;
    logic                       accept_s;
    logic [INT_DATA_W-1:0]      rd_data_s;

    // Request acceptance: only once the fill is done and the pipe can take it
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == IMEM_READY) && imem_req_valid && !stall && !flush) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Pre-write contents, so a same-cycle load is not visible to this read
    assign rd_data_s = mem_r[imem_req_addr];

    // Array writes: fill pattern during INIT, loader writes afterwards
    always_ff @(posedge clk) begin
        if (state_r == IMEM_INIT) begin
            mem_r[cnt_r] <= INIT_WORD;
        end else if (load_en) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Fill sequencer; the counter wraps to zero as it leaves INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IMEM_INIT;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                IMEM_INIT: begin
                    cnt_r <= cnt_r + {{(INSTR_MEM_IDX_W-1){1'b0}}, 1'b1};
                    if (is_last_idx(cnt_r)) begin
                        state_r <= IMEM_READY;
                        busy_r  <= 1'b0;
                    end
                end
                IMEM_READY: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    state_r <= IMEM_INIT;
                    cnt_r   <= '0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign busy = busy_r;

    imem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (accept_s),
        .in_addr   (imem_req_addr),
        .in_data   (rd_data_s),
        .out_valid (imem_resp_valid),
        .out_addr  (imem_resp_addr),
        .out_data  (imem_resp_data)
    );

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed plus random bench driving LATENCY=1 and LATENCY=3 instances in
// lockstep against a queue-based reference model.
module tb_instr_mem_responder;
    import instr_mem_responder_pkg::*;

    localparam int DEPTH = INSTR_MEM_DEPTH;
    localparam int AW    = INSTR_MEM_IDX_W;
    localparam int DW    = INT_DATA_W;
    localparam int LAT [2] = '{1, 3};

    logic          clk;
    logic          rst_n;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          stall;
    logic          flush;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    logic          v1, v3, b1, b3;
    logic [AW-1:0] a1, a3;
    logic [DW-1:0] d1, d3;

    instr_mem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .stall(stall), .flush(flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .imem_resp_valid(v1), .imem_resp_data(d1), .imem_resp_addr(a1),
        .busy(b1)
    );

    instr_mem_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .stall(stall), .flush(flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .imem_resp_valid(v3), .imem_resp_data(d3), .imem_resp_addr(a3),
        .busy(b3)
    );

    // Each in-flight request remembers how many edges it has aged.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            age;
    } ent_t;

    ent_t          q [2][$];
    logic [DW-1:0] mem_m [DEPTH];
    int            init_left;
    int            errors;
    int            checks;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rv, input int ra, input logic st, input logic fl,
                         input logic le, input int la, input logic [DW-1:0] ld);
        imem_req_valid = rv;
        imem_req_addr  = AW'(ra);
        stall          = st;
        flush          = fl;
        load_en        = le;
        load_addr      = AW'(la);
        load_data      = ld;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic model_step();
        logic ready;
        ent_t e;
        ready = (init_left == 0);
        if (init_left > 0) init_left--;
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                q[k].delete();
            end else if (!stall) begin
                for (int i = 0; i < q[k].size(); i++) q[k][i].age = q[k][i].age + 1;
                while (q[k].size() > 0 && q[k][0].age > LAT[k]) void'(q[k].pop_front());
                if (ready && imem_req_valid) begin
                    e.addr = imem_req_addr;
                    e.data = mem_m[imem_req_addr];
                    e.age  = 1;
                    q[k].push_back(e);
                end
            end
        end
        if (ready && load_en) mem_m[load_addr] = load_data;
    endtask

    task automatic check_outputs();
        logic          ov, ob, ev;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        for (int k = 0; k < 2; k++) begin
            ov = (k == 0) ? v1 : v3;
            ob = (k == 0) ? b1 : b3;
            oa = (k == 0) ? a1 : a3;
            od = (k == 0) ? d1 : d3;
            ev = (q[k].size() > 0) && (q[k][0].age == LAT[k]);
            check($sformatf("busy_L%0d", LAT[k]), 64'(ob), 64'(init_left != 0));
            check($sformatf("valid_L%0d", LAT[k]), 64'(ov), 64'(ev));
            if (ev) begin
                check($sformatf("data_L%0d", LAT[k]), 64'(od), 64'(q[k][0].data));
                check($sformatf("addr_L%0d", LAT[k]), 64'(oa), 64'(q[k][0].addr));
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) q[k].delete();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP_INSTR;
        init_left = DEPTH;
        check("rst_valid_L1", 64'(v1), 64'(0));
        check("rst_valid_L3", 64'(v3), 64'(0));
        check("rst_data_L1", 64'(d1), 64'(0));
        check("rst_data_L3", 64'(d3), 64'(0));
        check("rst_addr_L1", 64'(a1), 64'(0));
        check("rst_addr_L3", 64'(a3), 64'(0));
        check("rst_busy_L1", 64'(b1), 64'(1));
        check("rst_busy_L3", 64'(b3), 64'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        idle();
        #2;
        do_reset();

        // requests and loads during the fill must vanish
        drive(1'b1, 2, 1'b0, 1'b0, 1'b1, 2, 32'hdead_beef);
        for (int i = 0; i < DEPTH; i++) cycle();
        idle();
        cycle();

        // fresh array reads back the fill pattern
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        drive(1'b1, DEPTH-1, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        check("nop_last_L1", 64'(d1), 64'(NOP_INSTR));
        idle();
        for (int i = 0; i < 3; i++) cycle();

        // load then read
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 32'h1234_5678); cycle();
        drive(1'b1, 3, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        check("load_rd_valid", 64'(v1), 64'(1));
        check("load_rd_data", 64'(d1), 64'(32'h1234_5678));
        check("load_rd_addr", 64'(a1), 64'(3));

        // same-cycle load is not visible to the accepted read
        drive(1'b1, 7, 1'b0, 1'b0, 1'b1, 7, 32'hcafe_f00d); cycle();
        check("same_cyc_old", 64'(d1), 64'(NOP_INSTR));
        drive(1'b1, 7, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        check("later_new", 64'(d1), 64'(32'hcafe_f00d));
        idle();
        for (int i = 0; i < 3; i++) cycle();

        // streaming
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, a, 1'b0, 1'b0, 1'b0, 0, 32'h0);
            cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) cycle();

        // stall with two in flight
        drive(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        drive(1'b1, 3, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        drive(1'b1, 2, 1'b1, 1'b0, 1'b0, 0, 32'h0); cycle();
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 32'h0); cycle();
        idle();
        for (int i = 0; i < 4; i++) cycle();

        // flush with requests in flight and one in the same cycle
        for (int a = 4; a < 7; a++) begin
            drive(1'b1, a, 1'b0, 1'b0, 1'b0, 0, 32'h0);
            cycle();
        end
        drive(1'b1, 8, 1'b0, 1'b1, 1'b0, 0, 32'h0); cycle();
        drive(1'b1, 9, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        idle();
        for (int i = 0; i < 4; i++) cycle();

        // flush beats stall
        drive(1'b1, 10, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        drive(1'b1, 11, 1'b1, 1'b1, 1'b0, 0, 32'h0); cycle();
        idle();
        for (int i = 0; i < 4; i++) cycle();

        // random mix
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(1)), int'($urandom_range(DEPTH-1)),
                  1'($urandom_range(3) == 0), 1'($urandom_range(9) == 0),
                  1'($urandom_range(2) == 0), int'($urandom_range(DEPTH-1)),
                  32'($urandom));
            cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) cycle();

        // reset mid-flight discards responses and refills the array
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 32'h0bad_c0de); cycle();
        drive(1'b1, 3, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        drive(1'b1, 4, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        idle();
        #2;
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle();
        drive(1'b1, 3, 1'b0, 1'b0, 1'b0, 0, 32'h0); cycle();
        check("post_rst_valid", 64'(v1), 64'(1));
        check("post_rst_nop", 64'(d1), 64'(NOP_INSTR));
        idle();
        for (int i = 0; i < 4; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
